// File: rtl/ivn_collector_if.sv
// Stream bundle for ivn_collector: per-PE debiased bits in, packed words out.
// The collector connects as slave; the PE array / entropy sink side is master.
interface ivn_collector_if #(
    parameter int WORD_W = 32
);
    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [5:0]        s_vn;
    logic [5:0]        s_vn_valid;
    logic              out_ready;
    logic              out_valid;
    logic [WORD_W-1:0] out_data;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output s_vn, s_vn_valid, out_ready,
        input  out_valid, out_data, out_count
    );

    modport slave (
        input  s_vn, s_vn_valid, out_ready,
        output out_valid, out_data, out_count
    );
endinterface

// File: rtl/ivn_collector.sv
// Output collector for the 6-PE von Neumann debiaser: compacts valid bits, packs LSB-first
// into WORD_W-bit words with a flush FSM. Optional statistics behind `IVN_COLLECT_STATS_EN.
module ivn_collector #(
    parameter  int WORD_W = 32,
    localparam int CAP    = 2 * WORD_W,
    localparam int CNT_W  = $clog2(WORD_W + 1),
    localparam int FILL_W = $clog2(CAP + 1)
) (
    input  logic              clk,
    input  logic              reset,
    ivn_collector_if.slave    bus,
    input  logic              flush,
    output logic [FILL_W-1:0] fill,
    output logic              flush_busy,
    output logic              flush_done,
    output logic [15:0]       drop_cnt,
    output logic [31:0]       ones_cnt,
    output logic [31:0]       bits_cnt
);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + 17'(b);
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    state_e            state_q, state_d;
    logic              is_idle;
    logic [CAP-1:0]    acc_q, acc_d, acc_ap;
    logic [FILL_W-1:0] fill_q, fill_d, fill_ap;
    logic [FILL_W:0]   fill_sum;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic [15:0]       drop_q, drop_d;
    logic [5:0]        comp;
    logic [2:0]        n;
    logic              reg_free, pop_full, pop_part, append, drop;

    always_comb begin
        comp = '0;
        n    = '0;
        for (int i = 0; i < 6; i++) begin
            if (bus.s_vn_valid[i]) begin
                comp[n] = bus.s_vn[i];
                n       = n + 3'd1;
            end
        end
    end

    // Pop is decided first from registered state; append is checked against post-pop fill.
    always_comb begin
        reg_free    = !out_valid_q || bus.out_ready;
        pop_full    = reg_free && (fill_q >= FILL_W'(WORD_W));
        pop_part    = reg_free && (state_q == DRAIN) && (fill_q != '0) && !pop_full;
        acc_ap      = acc_q;
        fill_ap     = fill_q;
        if (pop_full) begin
            acc_ap  = acc_q >> WORD_W;
            fill_ap = fill_q - FILL_W'(WORD_W);
        end else if (pop_part) begin
            acc_ap  = '0;
            fill_ap = '0;
        end
        fill_sum    = {1'b0, fill_ap} + (FILL_W+1)'(n);
        append      = is_idle && (fill_sum <= (FILL_W+1)'(CAP));
        drop        = (n != 3'd0) && !append;
        acc_d       = append ? (acc_ap | ({{(CAP-6){1'b0}}, comp} << fill_ap)) : acc_ap;
        fill_d      = append ? fill_sum[FILL_W-1:0] : fill_ap;
        drop_d      = drop ? sat_add16(drop_q, n) : drop_q;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (reg_free) begin
            out_valid_d = pop_full || pop_part;
            if (pop_full) begin
                out_data_d  = acc_q[WORD_W-1:0];
                out_count_d = CNT_W'(WORD_W);
            end else if (pop_part) begin
                out_data_d  = acc_q[WORD_W-1:0];
                out_count_d = fill_q[CNT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            drop_q      <= '0;
        end else begin
            acc_q       <= acc_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (flush) state_d = DRAIN;
            DRAIN:   if (fill_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        is_idle    = (state_q == IDLE);
        flush_busy = (state_q != IDLE);
        flush_done = (state_q == DONE);
    end

`ifdef IVN_COLLECT_STATS_EN
    logic [31:0] bits_q, ones_q;
    logic [2:0]  ones_n;

    always_comb begin
        ones_n = '0;
        for (int i = 0; i < 6; i++) ones_n = ones_n + {2'b00, comp[i]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bits_q <= '0;
            ones_q <= '0;
        end else if (append) begin
            bits_q <= bits_q + 32'(n);
            ones_q <= ones_q + 32'(ones_n);
        end
    end

    assign bits_cnt = bits_q;
    assign ones_cnt = ones_q;
`else
    assign bits_cnt = '0;
    assign ones_cnt = '0;
`endif

    assign fill          = fill_q;
    assign drop_cnt      = drop_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_ivn_collector.sv
// Directed bench for ivn_collector at WORD_W=8: reset, packing order, backpressure, flush, stats.
module tb_ivn_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [4:0]  fill;
    logic        flush_busy, flush_done;
    logic [15:0] drop_cnt;
    logic [31:0] ones_cnt, bits_cnt;
    int          checks = 0;
    int          errors = 0;

    ivn_collector_if #(.WORD_W(8)) bus();

    ivn_collector #(.WORD_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .flush      (flush),
        .fill       (fill),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .drop_cnt   (drop_cnt),
        .ones_cnt   (ones_cnt),
        .bits_cnt   (bits_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] vld, input logic [5:0] vn);
        bus.s_vn_valid = vld;
        bus.s_vn       = vn;
    endtask

    initial begin
        // Reset with random inputs
        reset = 1'b1;
        flush = 1'($urandom);
        bus.out_ready = 1'($urandom);
        drive(6'($urandom), 6'($urandom));
        tick();
        flush = 1'($urandom);
        drive(6'($urandom), 6'($urandom));
        tick();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_count", 64'(bus.out_count), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_busy", 64'(flush_busy), 64'd0);
        check("rst_done", 64'(flush_done), 64'd0);
        check("rst_drop", 64'(drop_cnt), 64'd0);
        check("rst_bits", 64'(bits_cnt), 64'd0);
        check("rst_ones", 64'(ones_cnt), 64'd0);
        reset = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(6'b0, 6'b0);
        tick();

        // Sparse pack: bits 1,0 per cycle -> 8'h55
        drive(6'b000101, 6'b000001);
        tick();
        check("sparse_fill1", 64'(fill), 64'd2);
        tick();
        tick();
        tick();
        check("sparse_fill4", 64'(fill), 64'd8);
        check("sparse_nv4", 64'(bus.out_valid), 64'd0);
        drive(6'b0, 6'b0);
        tick();
        check("sparse_valid", 64'(bus.out_valid), 64'd1);
        check("sparse_data", 64'(bus.out_data), 64'h55);
        check("sparse_count", 64'(bus.out_count), 64'd8);
        check("sparse_fill0", 64'(fill), 64'd0);
        tick();
        check("sparse_accepted", 64'(bus.out_valid), 64'd0);

        // Order: PE0 earliest; 0,1,0,1,0,1 then 1,0 -> 8'h6A
        drive(6'b111111, 6'b101010);
        tick();
        check("order_fillA", 64'(fill), 64'd6);
        drive(6'b000011, 6'b000001);
        tick();
        drive(6'b0, 6'b0);
        tick();
        check("order_valid", 64'(bus.out_valid), 64'd1);
        check("order_data", 64'(bus.out_data), 64'h6A);
        check("order_fill", 64'(fill), 64'd0);
        tick();

        // Backpressure: stream 1,1,0,0,1,1 repeating, sink stalled
        bus.out_ready = 1'b0;
        drive(6'b111111, 6'b110011);
        tick();
        tick();
        check("bp_fill2", 64'(fill), 64'd12);
        tick();
        check("bp_valid", 64'(bus.out_valid), 64'd1);
        check("bp_data", 64'(bus.out_data), 64'hF3);
        check("bp_fill3", 64'(fill), 64'd10);
        tick();
        check("bp_fill_cap", 64'(fill), 64'd16);
        check("bp_drop0", 64'(drop_cnt), 64'd0);
        tick();
        check("bp_drop6", 64'(drop_cnt), 64'd6);
        check("bp_fill_held", 64'(fill), 64'd16);
        tick();
        check("bp_drop12", 64'(drop_cnt), 64'd12);
        check("bp_data_stable", 64'(bus.out_data), 64'hF3);
        bus.out_ready = 1'b1;
        drive(6'b0, 6'b0);
        tick();
        check("bp_w2_data", 64'(bus.out_data), 64'h3C);
        check("bp_w2_fill", 64'(fill), 64'd8);
        tick();
        check("bp_w3_data", 64'(bus.out_data), 64'hCF);
        check("bp_w3_valid", 64'(bus.out_valid), 64'd1);
        check("bp_w3_fill", 64'(fill), 64'd0);
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'd0);
        check("bp_drop_final", 64'(drop_cnt), 64'd12);

        // Flush partial: bits 1,1,0 then flush
        drive(6'b000111, 6'b000011);
        tick();
        check("fl_fill", 64'(fill), 64'd3);
        drive(6'b0, 6'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_busy", 64'(flush_busy), 64'd1);
        drive(6'b111111, 6'b111111);
        tick();
        drive(6'b0, 6'b0);
        check("fl_valid", 64'(bus.out_valid), 64'd1);
        check("fl_data", 64'(bus.out_data), 64'h03);
        check("fl_count", 64'(bus.out_count), 64'd3);
        check("fl_fill0", 64'(fill), 64'd0);
        check("fl_drop", 64'(drop_cnt), 64'd18);
        check("fl_done_early", 64'(flush_done), 64'd0);
        tick();
        check("fl_done", 64'(flush_done), 64'd1);
        tick();
        check("fl_done_clr", 64'(flush_done), 64'd0);
        check("fl_idle", 64'(flush_busy), 64'd0);

        // Flush with nothing buffered
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl0_busy", 64'(flush_busy), 64'd1);
        check("fl0_done_t1", 64'(flush_done), 64'd0);
        tick();
        check("fl0_done_t2", 64'(flush_done), 64'd1);
        check("fl0_no_word", 64'(bus.out_valid), 64'd0);
        tick();
        check("fl0_idle", 64'(flush_busy), 64'd0);

        // Stats: fresh reset, 20 appended bits with 9 ones, 6 dropped during drain
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("st_rst_drop", 64'(drop_cnt), 64'd0);
        check("st_rst_bits", 64'(bits_cnt), 64'd0);
        drive(6'b111111, 6'b000111);
        tick();
        tick();
        drive(6'b111111, 6'b000001);
        tick();
        drive(6'b000011, 6'b000011);
        tick();
        check("st_fill", 64'(fill), 64'd4);
        drive(6'b0, 6'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(6'b111111, 6'b111111);
        tick();
        drive(6'b0, 6'b0);
        check("st_drop", 64'(drop_cnt), 64'd6);
        check("st_part_data", 64'(bus.out_data), 64'h0C);
        check("st_part_count", 64'(bus.out_count), 64'd4);
`ifdef IVN_COLLECT_STATS_EN
        check("st_bits", 64'(bits_cnt), 64'd20);
        check("st_ones", 64'(ones_cnt), 64'd9);
`else
        check("st_bits_off", 64'(bits_cnt), 64'd0);
        check("st_ones_off", 64'(ones_cnt), 64'd0);
`endif
        tick();
        check("st_done", 64'(flush_done), 64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ivn_collector.md
# ivn_collector

Output collector for the 6-PE iterated von Neumann debiaser. Each cycle it takes the parallel `s_vn`/`s_vn_valid` vectors, compacts the valid bits in PE index order, and packs them LSB-first into `WORD_W`-bit words. Words leave through a valid/ready stream toward the entropy sink. A flush sequence drains partial words at lane or run boundaries.

## Interface
- `WORD_W`, default 32: output word width. Legal range is 8 to 64.
- `CAP`, fixed at 2*`WORD_W`: accumulator capacity in bits. This is a localparam.
- `clk`  input  1  clock; all logic is rising-edge.
- `reset`  input  1  reset, synchronous, active-high.
- `s_vn`  input  6  debiased bit per PE.
- `s_vn_valid`  input  6  per-PE bit-valid mask.
- `flush`  input  1  single-cycle request to drain all buffered bits.
- `out_ready`  input  1  sink accepts the current word.
- `out_valid`  output  1  `out_data`/`out_count` hold a word.
- `out_data`  output  `WORD_W`  packed bits. Earliest bit is at [0]; unused upper bits are 0.
- `out_count`  output  clog2(`WORD_W`+1)  number of meaningful bits in `out_data`.
- `fill`  output  clog2(`CAP`+1)  bits currently held in the accumulator.
- `flush_busy`  output  1  flush FSM not in IDLE.
- `flush_done`  output  1  one-cycle pulse when the flush completes.
- `drop_cnt`  output  16  saturating count of discarded input bits.
- `ones_cnt`, `bits_cnt`  output  32 each  statistics; see Configuration.

## Operation
- Compaction:
  - n = popcount(`s_vn_valid`), range 0..6.
  - Valid bits are ordered by ascending PE index. PE0 is the earliest bit.
- Output register state:
  - The output register is free when `out_valid`==0, or when `out_valid`&&`out_ready` (handshake this cycle).
- Per-cycle evaluation order, all from registered state:
  1. Pop. Pop when the register is free and `fill`>=`WORD_W`:
     - load the low `WORD_W` accumulator bits into `out_data`;
     - set `out_count`=`WORD_W` and `out_valid`=1;
     - shift the accumulator down by `WORD_W`.
     
     If the register is free and there is no pop, `out_valid` clears.
  2. Append. Append only when fill_after_pop + n <= `CAP` and the FSM is IDLE. The bits go in at position fill_after_pop.
     - If capacity is exceeded, all n bits are dropped.
     - If the FSM is not IDLE, all n bits are dropped.
     - Dropped bits add n to `drop_cnt`, which saturates at 16'hFFFF.
- Flush FSM:
  - IDLE: `flush`=1 goes to DRAIN. A `flush` that arrives while not IDLE is ignored.
  - DRAIN:
    - Full words pop normally.
    - When 0<`fill`<`WORD_W` and the register is free: load the partial word with `out_count`=`fill`, zero the upper bits, set `fill`=0.
    - When `fill`==0, go to DONE.
  - DONE: pulse `flush_done`, then return to IDLE the next cycle.
  - A flush with `fill`==0 completes DRAIN→DONE→IDLE. `flush_done` is high 2 cycles after `flush` is sampled.
- `out_data`/`out_count` are held stable while `out_valid`&&!`out_ready`.

## Timing
- Reset values: every output and all internal state are 0, and the FSM is IDLE. A reset during DRAIN discards everything, including a pending word, and produces no `flush_done`.
- Append latency: a bit sampled at edge t is counted in `fill` after edge t.
- Word latency: when the word-completing input is sampled at edge t, `out_valid` rises after edge t+1, provided the output register is free.
- Throughput: one word per cycle under continuous `out_ready`. Sustained input of 6 bits/cycle never drops for `WORD_W`>=8.
- Backpressure: with `out_ready`=0, the block accepts up to `WORD_W` held in the output register plus `CAP` in the accumulator, then drops.
- Pop and append in the same cycle are legal. Capacity is checked against the post-pop fill.

## Configuration
- `IVN_COLLECT_STATS_EN` defined:
  - `bits_cnt` increments by the number of appended bits.
  - `ones_cnt` increments by the number of appended 1s.
  - Both wrap modulo 2^32 and clear on reset.
  - Dropped bits are not counted.
- `IVN_COLLECT_STATS_EN` undefined: both ports are tied to 0 and no counter flops are inferred.

## Test plan
All scenarios use `WORD_W`=8 and, unless stated, `out_ready`=1.
- Reset: assert `reset` 2 cycles with random inputs -> all outputs 0 and FSM IDLE.
- Sparse pack:
  - Stimulus: `s_vn_valid`=6'b000101, `s_vn`=6'b000001 for 4 cycles.
  - Response: one word, `out_data`=8'h55, `out_count`=8, `out_valid` rising 2 edges after the 4th input.
- Order check:
  - Stimulus: cycle A has valid=6'b111111 with `s_vn`=6'b101010; cycle B has valid=6'b000011 with `s_vn`=6'b000001.
  - Response: `out_data`=8'h6A, `fill`=0 afterwards.
- Backpressure:
  - Stimulus: `out_ready`=0, 6 valid bits per cycle.
  - Response: `out_data` stable, `fill` caps at 16, then `drop_cnt` +6 per cycle. Releasing `out_ready` drains 3 words with no further drops.
- Flush partial:
  - Stimulus: 3 bits 1,1,0, then `flush`.
  - Response: `out_data`=8'h03, `out_count`=3, then `flush_done` pulse. Bits arriving during DRAIN add to `drop_cnt`.
- Stats (macro on):
  - Stimulus: 20 appended bits with 9 ones, plus 6 dropped.
  - Response: `bits_cnt`=20, `ones_cnt`=9. With the macro off, both read 0.
